// File: rtl/rd_sub_pipe.sv
// rd_sub_pipe: pipelined recursive-doubling subtractor, diff = a - b - bin.
// The borrow chain is computed as a + ~b + ~bin. Kill/propagate/generate codes
// are resolved by a doubling network with one register stage per level.
// Operands travel through the pipe as propagate bits next to their codes.
`timescale 1ns/1ps

module rd_sub_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    // Code at position j is {hi, lo}: kill = 00, generate = 11, propagate = 10.
    // Position 0 holds the carry-in code and position j > 0 holds bit j-1.
    // Once resolved, lo[j] is the carry into bit j.
    logic [WIDTH:0]   hi_q [0:LEVELS];
    logic [WIDTH:0]   lo_q [0:LEVELS];
    logic [WIDTH-1:0] p_q  [0:LEVELS];
    logic [LEVELS:0]  v_q;

    logic [WIDTH:0]   hi_n [1:LEVELS];
    logic [WIDTH:0]   lo_n [1:LEVELS];

    logic             stall;
    logic             top_prop;
    logic             carry_out;

    assign stall    = v_q[LEVELS] & ~out_ready;
    assign in_ready = ~stall;

    // Doubling step per level: a propagate position takes the code d places below.
    always_comb begin
        for (int k = 1; k <= int'(LEVELS); k++) begin
            hi_n[k] = hi_q[k-1];
            lo_n[k] = lo_q[k-1];
            for (int i = (1 << (k - 1)); i <= int'(WIDTH); i++) begin
                if (hi_q[k-1][i] && !lo_q[k-1][i]) begin
                    hi_n[k][i] = hi_q[k-1][i - (1 << (k - 1))];
                    lo_n[k][i] = lo_q[k-1][i - (1 << (k - 1))];
                end
            end
        end
    end

    // Pipeline registers: S0 captures operands on accept; the whole pipe holds on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= int'(LEVELS); k++) begin
                hi_q[k] <= '0;
                lo_q[k] <= '0;
                p_q[k]  <= '0;
            end
            v_q <= '0;
        end else if (!stall) begin
            hi_q[0] <= {a | ~b, ~bin};
            lo_q[0] <= {a & ~b, ~bin};
            p_q[0]  <= a ^ ~b;
            for (int k = 1; k <= int'(LEVELS); k++) begin
                hi_q[k] <= hi_n[k];
                lo_q[k] <= lo_n[k];
                p_q[k]  <= p_q[k-1];
            end
            v_q <= {v_q[LEVELS-1:0], in_valid};
        end
    end

    // The doubling reach covers WIDTH positions, so the carry-out position can
    // still be propagate when every bit propagates; it then inherits the carry-in.
    assign top_prop  = hi_q[LEVELS][WIDTH] & ~lo_q[LEVELS][WIDTH];
    assign carry_out = top_prop ? lo_q[LEVELS][0] : lo_q[LEVELS][WIDTH];

    // Result decode from the last stage registers only.
    assign out_valid = v_q[LEVELS];
    assign diff      = p_q[LEVELS] ^ lo_q[LEVELS][WIDTH-1:0];
    assign borrow    = v_q[LEVELS] & ~carry_out;
    assign zero      = v_q[LEVELS] & (diff == '0);

endmodule
